// File: rtl/cc_seq_calc_if.sv
// cc_seq_calc_if: streaming operand/opt input and result output for cc_seq_calc.
interface cc_seq_calc_if #(
    parameter int unsigned W  = 4,
    parameter int unsigned OW = 10
);
    logic          in_valid;
    logic [2:0]    opt;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [OW-1:0] out_data;

    // Source side: drives operands, observes readiness and results.
    modport master (
        output in_valid, opt, in_data,
        input  in_ready, out_valid, out_data
    );

    // Calculator side.
    modport slave (
        input  in_valid, opt, in_data,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/cc_seq_calc.sv
// cc_seq_calc: loads a burst of N operands, sorts them (odd-even transposition),
// normalises about the mid-range and reduces them serially to one signed result.
// Optional feature macro CC_SAT_EN: when defined the result saturates to the
// signed OW range; otherwise it wraps modulo 2^OW.
module cc_seq_calc #(
    parameter int unsigned N  = 5,
    parameter int unsigned W  = 4,
    parameter int unsigned OW = 10
) (
    input  logic         clk,
    input  logic         rst,
    cc_seq_calc_if.slave bus
);
    localparam int unsigned EW = W + 2;
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned AW = W + $clog2(N) + 2;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SORT, S_NORM, S_CALC, S_OUT
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_opt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_inc;
    logic signed [EW-1:0] r_ops [N];
    logic signed [EW-1:0] w_sort [N];
    logic signed [AW-1:0] r_acc;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [OW-1:0]        r_out_data;

    logic                 w_sgn;
    logic signed [EW-1:0] w_in_ext;
    logic signed [EW-1:0] w_avg;
    logic signed [AW-1:0] w_cur_x;
    logic signed [AW-1:0] w_acc_nxt;
    logic [OW-1:0]        w_res;
    logic                 w_in_ready_nxt;
    logic                 w_out_valid_nxt;
    logic [OW-1:0]        w_out_data_nxt;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

    // Operand extension to the internal width; signedness comes from the burst opt.
    assign w_sgn     = (r_state == S_IDLE) ? bus.opt[0] : r_opt[0];
    assign w_in_ext  = {{2{w_sgn & bus.in_data[W-1]}}, bus.in_data};
    assign w_cnt_inc = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);

    // One odd-even transposition pass; pass parity follows the cycle counter.
    always_comb begin
        w_sort = r_ops;
        for (int i = 0; i < int'(N) - 1; i++) begin
            if (1'(i) == r_cnt[0]) begin
                if (r_opt[1] ? (r_ops[i] < r_ops[i+1]) : (r_ops[i] > r_ops[i+1])) begin
                    w_sort[i]   = r_ops[i+1];
                    w_sort[i+1] = r_ops[i];
                end
            end
        end
    end

    // Mid-range of the sorted set: first and last element are min/max in either order.
    assign w_avg = (r_ops[0] + r_ops[N-1]) >>> 1;

    // Serial reduction step over the normalised operand selected by the counter.
    always_comb begin
        w_cur_x = {{(AW-EW){r_ops[r_cnt][EW-1]}}, r_ops[r_cnt]};
        if (!r_opt[2]) begin
            w_acc_nxt = r_acc + (w_cur_x[AW-1] ? -w_cur_x : w_cur_x);
        end else if (r_cnt == '0) begin
            w_acc_nxt = w_cur_x;
        end else begin
            w_acc_nxt = (r_acc + w_cur_x) >>> 1;
        end
    end

`ifdef CC_SAT_EN
    localparam int unsigned XW = (AW > OW) ? AW : OW;
    localparam logic signed [XW-1:0] SAT_MAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    logic signed [XW-1:0] w_res_x;

    // Clamp the final accumulator to the signed output range.
    always_comb begin
        w_res_x = XW'(w_acc_nxt);
        if (w_res_x > SAT_MAX) begin
            w_res = SAT_MAX[OW-1:0];
        end else if (w_res_x < SAT_MIN) begin
            w_res = SAT_MIN[OW-1:0];
        end else begin
            w_res = w_res_x[OW-1:0];
        end
    end
`else
    // Wrap the final accumulator modulo 2^OW.
    always_comb begin
        w_res = OW'(w_acc_nxt);
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an early in_valid drop discards the burst.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (!bus.in_valid)      w_state_nxt = S_IDLE;
                else if (r_cnt == LAST) w_state_nxt = S_SORT;
            end
            S_SORT: if (r_cnt == LAST) w_state_nxt = S_NORM;
            S_NORM: w_state_nxt = S_CALC;
            S_CALC: if (r_cnt == LAST) w_state_nxt = S_OUT;
            S_OUT:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output values for the next cycle, decoded from the next state.
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_out_data_nxt  = '0;
        case (w_state_nxt)
            S_IDLE, S_LOAD: w_in_ready_nxt = 1'b1;
            S_OUT: begin
                w_out_valid_nxt = 1'b1;
                w_out_data_nxt  = w_res;
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

    // Datapath: operand load, sort passes, normalisation and accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opt <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            for (int i = 0; i < int'(N); i++) r_ops[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_opt    <= bus.opt;
                        r_ops[0] <= w_in_ext;
                        r_cnt    <= CW'(1);
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        r_ops[r_cnt] <= w_in_ext;
                        r_cnt        <= w_cnt_inc;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                S_SORT: begin
                    r_ops <= w_sort;
                    r_cnt <= w_cnt_inc;
                end
                S_NORM: begin
                    for (int i = 0; i < int'(N); i++) r_ops[i] <= r_ops[i] - w_avg;
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cc_seq_calc.sv
// tb_cc_seq_calc: scoreboard bench for cc_seq_calc (N=5/OW=10 and N=8/OW=5 instances).
module tb_cc_seq_calc;
    localparam int NA = 5, WA = 4, OWA = 10;
    localparam int NB = 8, WB = 4, OWB = 5;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct { int data; int cyc; } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cc_seq_calc_if #(.W(WA), .OW(OWA)) bus_a ();
    cc_seq_calc_if #(.W(WB), .OW(OWB)) bus_b ();

    cc_seq_calc #(.N(NA), .W(WA), .OW(OWA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    cc_seq_calc #(.N(NB), .W(WB), .OW(OWB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Independent reference: plain integer sort/normalise/reduce.
    function automatic int model(input logic [2:0] o, input int vals[8], input int n,
                                 input int w, input int ow);
        int s[8];
        int t, avg, acc, nv, lim;
        for (int i = 0; i < n; i++)
            s[i] = (o[0] && vals[i] >= (1 << (w - 1))) ? vals[i] - (1 << w) : vals[i];
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n - 1 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        avg = (s[0] + s[n-1]) >>> 1;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            nv = (o[1] ? s[n-1-k] : s[k]) - avg;
            if (!o[2])       acc += (nv < 0) ? -nv : nv;
            else if (k == 0) acc = nv;
            else             acc = (acc + nv) >>> 1;
        end
        lim = 1 << (ow - 1);
`ifdef CC_SAT_EN
        if (acc > lim - 1) acc = lim - 1;
        if (acc < -lim)    acc = -lim;
`endif
        return acc & ((1 << ow) - 1);
    endfunction

    function automatic int get_ready(input int sel);
        return (sel == 0) ? int'(bus_a.in_ready) : int'(bus_b.in_ready);
    endfunction

    task automatic drive_op(input int sel, input logic v, input logic [2:0] o, input int d);
        if (sel == 0) begin
            bus_a.in_valid = v; bus_a.opt = o; bus_a.in_data = WA'(d);
        end else begin
            bus_b.in_valid = v; bus_b.opt = o; bus_b.in_data = WB'(d);
        end
    endtask

    // Waits (bounded) for in_ready, drives len operands, optionally queues the expected result.
    task automatic send_burst(input int sel, input logic [2:0] o, input int vals[8],
                              input int len, input bit push, input int exp_val,
                              output int last);
        int   n;
        int   guard;
        exp_t e;
        n = (sel == 0) ? NA : NB;
        guard = 0;
        @(posedge clk); #1;
        while (get_ready(sel) == 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("ready_before_burst", get_ready(sel), 1);
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            drive_op(sel, 1'b1, (i == 0) ? o : ~o, vals[i]);
        end
        last = cyc;
        if (push) begin
            e.data = exp_val;
            e.cyc  = last + 2 * n + 2;
            if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
        end
        @(posedge clk); #1;
        drive_op(sel, 1'b0, 3'b000, 0);
    endtask

    // Scoreboard monitors: compare data and exact cycle of every result strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.out_valid) begin
                if (q_a.size() == 0) begin
                    check_eq("a_unexpected_out_valid", int'(bus_a.out_valid), 0);
                end else begin
                    e_a = q_a.pop_front();
                    check_eq("a_out_data", int'(bus_a.out_data), e_a.data);
                    check_eq("a_latency_cycle", cyc, e_a.cyc);
                end
            end else begin
                check_eq("a_out_data_idle", int'(bus_a.out_data), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_b.out_valid) begin
                if (q_b.size() == 0) begin
                    check_eq("b_unexpected_out_valid", int'(bus_b.out_valid), 0);
                end else begin
                    e_b = q_b.pop_front();
                    check_eq("b_out_data", int'(bus_b.out_data), e_b.data);
                    check_eq("b_latency_cycle", cyc, e_b.cyc);
                end
            end else begin
                check_eq("b_out_data_idle", int'(bus_b.out_data), 0);
            end
        end
    end

    initial begin
        int v[8];
        int last;
        int guard;
        int sel, n, ow;
        logic [2:0] o;

        rst = 1'b1;
        drive_op(0, 1'b0, 3'b000, 0);
        drive_op(1, 1'b0, 3'b000, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_a_in_ready",  int'(bus_a.in_ready), 1);
        check_eq("rst_a_out_valid", int'(bus_a.out_valid), 0);
        check_eq("rst_a_out_data",  int'(bus_a.out_data), 0);
        check_eq("rst_b_in_ready",  int'(bus_b.in_ready), 1);
        check_eq("rst_b_out_valid", int'(bus_b.out_valid), 0);
        rst = 1'b0;

        // Ascending abs-sum, unsigned.
        v = '{3, 9, 1, 7, 5, 0, 0, 0};
        send_burst(0, 3'b000, v, NA, 1'b1, 12, last);

        // Signed, descending, cumulate: expect -3.
        v = '{15, 8, 2, 7, 0, 0, 0, 0};
        send_burst(0, 3'b111, v, NA, 1'b1, 10'h3FD, last);

        // Aborted 3-operand burst then a full one: single result.
        v = '{3, 9, 1, 7, 5, 0, 0, 0};
        send_burst(0, 3'b000, v, 3, 1'b0, 0, last);
        send_burst(0, 3'b000, v, NA, 1'b1, 12, last);

        // Reset while sorting, then a fresh burst.
        v = '{15, 8, 2, 7, 0, 0, 0, 0};
        send_burst(0, 3'b111, v, NA, 1'b0, 0, last);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_a_out_valid", int'(bus_a.out_valid), 0);
        check_eq("midrst_a_out_data",  int'(bus_a.out_data), 0);
        check_eq("midrst_a_in_ready",  int'(bus_a.in_ready), 1);
        rst = 1'b0;
        v = '{3, 9, 1, 7, 5, 0, 0, 0};
        send_burst(0, 3'b000, v, NA, 1'b1, 12, last);

        // in_valid pulsed during CALC must be ignored.
        send_burst(0, 3'b000, v, NA, 1'b1, 12, last);
        while (cyc < last + NA + 2) begin @(posedge clk); #1; end
        for (int i = 0; i < 2; i++) begin
            drive_op(0, 1'b1, 3'b111, 15);
            check_eq("calc_in_ready_low", int'(bus_a.in_ready), 0);
            @(posedge clk); #1;
        end
        drive_op(0, 1'b0, 3'b000, 0);

        // N=8, OW=5 overflow: sum 60 saturates to 15 or wraps to 28.
        v = '{0, 15, 0, 15, 0, 15, 0, 15};
`ifdef CC_SAT_EN
        send_burst(1, 3'b000, v, NB, 1'b1, 15, last);
`else
        send_burst(1, 3'b000, v, NB, 1'b1, 28, last);
`endif

        // Random bursts on both instances against the integer model.
        for (int k = 0; k < 12; k++) begin
            sel = k % 2;
            n   = (sel == 0) ? NA : NB;
            ow  = (sel == 0) ? OWA : OWB;
            o   = 3'($urandom_range(0, 7));
            for (int i = 0; i < 8; i++) v[i] = (i < n) ? int'($urandom_range(0, 15)) : 0;
            send_burst(sel, o, v, n, 1'b1, model(o, v, n, 4, ow), last);
        end

        guard = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        repeat (30) @(posedge clk);
        check_eq("a_scoreboard_drained", q_a.size(), 0);
        check_eq("b_scoreboard_drained", q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
